// File: rtl/keypad_reader.sv
// 4x4 matrix keypad scanner with debounce and an 8-digit entry buffer.
// The CPU reads the buffer and the entry-complete flag through two fixed addresses.
module keypad_reader #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        keyCtrl,
  input  logic [31:0] address,
  output logic [3:0]  col,
  output logic [31:0] keyData,
  output logic        keyValid
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [31:0] ADDR_BUF   = 32'hFFFF_FFF4;
  localparam logic [31:0] ADDR_VALID = 32'hFFFF_FFF8;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [3:0]         row_s1_q, row_s2_q;
  logic [DIV_W-1:0]   div_q;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         col_q;
  logic [3:0]         code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rel_q, rel_d;
  logic [31:0]        buf_q, buf_d;
  logic               valid_q, valid_d;

  logic               tick_c;
  logic               key_c;
  logic [1:0]         r_c;
  logic [3:0]         samp_code_c;
  logic               reg_fire_c;
  logic [3:0]         digit_c;
  logic               rd_clr_c;

  // Physical position {col,row} to keypad legend.
  function automatic logic [3:0] code_to_digit(input logic [3:0] code);
    logic [3:0] d;
    case (code)
      4'h0: d = 4'h1;  4'h4: d = 4'h2;  4'h8: d = 4'h3;  4'hC: d = 4'hA;
      4'h1: d = 4'h4;  4'h5: d = 4'h5;  4'h9: d = 4'h6;  4'hD: d = 4'hB;
      4'h2: d = 4'h7;  4'h6: d = 4'h8;  4'hA: d = 4'h9;  4'hE: d = 4'hC;
      4'h3: d = 4'hE;  4'h7: d = 4'h0;  4'hB: d = 4'hF;  default: d = 4'hD;
    endcase
    return d;
  endfunction

  assign tick_c = (div_q == DIV_W'(SCAN_DIV - 1));

  // Only a single low row counts as a key; anything else is treated as idle.
  always_comb begin
    key_c = 1'b1;
    r_c   = 2'd0;
    case (row_s2_q)
      4'b1110: r_c = 2'd0;
      4'b1101: r_c = 2'd1;
      4'b1011: r_c = 2'd2;
      4'b0111: r_c = 2'd3;
      default: key_c = 1'b0;
    endcase
  end

  assign samp_code_c = {idx_q, r_c};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    rel_d      = rel_q;
    reg_fire_c = 1'b0;
    if (tick_c) begin
      case (state_q)
        SCAN: begin
          if (key_c) begin
            code_d = samp_code_c;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_CNT <= 1) begin
              reg_fire_c = 1'b1;
              rel_d      = '0;
              state_d    = HOLD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (key_c && (samp_code_c == code_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(DEBOUNCE_CNT)) begin
              reg_fire_c = 1'b1;
              rel_d      = '0;
              state_d    = HOLD;
            end
          end else begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = SCAN;
          end
        end
        HOLD: begin
          if (key_c) begin
            rel_d = '0;
          end else begin
            rel_d = rel_q + CNT_W'(1);
            if (rel_d == CNT_W'(DEBOUNCE_CNT)) begin
              rel_d   = '0;
              cnt_d   = '0;
              idx_d   = idx_q + 2'd1;
              state_d = SCAN;
            end
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign digit_c  = code_to_digit(code_d);
  assign rd_clr_c = keyCtrl && (address == ADDR_BUF) && valid_q;

  // Entry buffer; a read-clear takes priority over a key registered on the same edge.
  always_comb begin
    buf_d   = buf_q;
    valid_d = valid_q;
    if (rd_clr_c) begin
      buf_d   = '0;
      valid_d = 1'b0;
    end else if (reg_fire_c) begin
      case (digit_c)
        4'hE: begin
          buf_d   = '0;
          valid_d = 1'b0;
        end
        4'hF: valid_d = 1'b1;
        default: if (!valid_q) buf_d = {buf_q[27:0], digit_c};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SCAN;
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      div_q    <= '0;
      idx_q    <= 2'd0;
      col_q    <= 4'b1110;
      code_q   <= '0;
      cnt_q    <= '0;
      rel_q    <= '0;
      buf_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      div_q    <= tick_c ? '0 : div_q + DIV_W'(1);
      idx_q    <= idx_d;
      col_q    <= 4'(~(4'b0001 << idx_d));
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      buf_q    <= buf_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    keyData = '0;
    if (address == ADDR_BUF)        keyData = buf_q;
    else if (address == ADDR_VALID) keyData = {31'b0, valid_q};
  end

  assign col      = col_q;
  assign keyValid = valid_q;

endmodule

// File: tb/tb_keypad_reader.sv
// Directed bench for keypad_reader: a behavioural keypad drives rows from col,
// expected buffer/flag values are queued per key and compared on CPU reads.
module tb_keypad_reader;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 2;
  localparam logic [31:0] A_BUF = 32'hFFFF_FFF4;
  localparam logic [31:0] A_VLD = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic        keyCtrl;
  logic [31:0] address;
  logic [3:0]  col;
  logic [31:0] keyData;
  logic        keyValid;

  keypad_reader #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .keyCtrl  (keyCtrl),
    .address  (address),
    .col      (col),
    .keyData  (keyData),
    .keyValid (keyValid)
  );

  always #5 clk = ~clk;

  logic       press_en = 1'b0;
  logic [1:0] press_r  = 2'd0;
  logic [1:0] press_c  = 2'd0;
  logic       ovr_en   = 1'b0;
  logic [3:0] ovr_val  = 4'hF;

  // Pressed key shorts its row low only while its column is driven.
  always_comb begin
    row = 4'hF;
    if (ovr_en) row = ovr_val;
    else if (press_en && (col[press_c] == 1'b0)) row[press_r] = 1'b0;
  end

  logic [3:0] keymap [0:3][0:3] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                    '{4'h4, 4'h5, 4'h6, 4'hB},
                                    '{4'h7, 4'h8, 4'h9, 4'hC},
                                    '{4'hE, 4'h0, 4'hF, 4'hD}};

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] m_buf  = '0;
  logic        m_valid = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push_state(input string tag);
    sb.push_back('{{tag, "_buf"}, A_BUF, m_buf});
    sb.push_back('{{tag, "_vld"}, A_VLD, {31'b0, m_valid}});
  endtask

  task automatic drain(input string tag);
    exp_t e;
    keyCtrl = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      address = e.addr;
      #1;
      check(e.tag, keyData, e.exp);
    end
    check({tag, "_kv"}, {31'b0, keyValid}, {31'b0, m_valid});
  endtask

  task automatic apply_digit(input logic [3:0] d);
    if (d == 4'hE) begin
      m_buf   = '0;
      m_valid = 1'b0;
    end else if (d == 4'hF) begin
      m_valid = 1'b1;
    end else if (!m_valid) begin
      m_buf = {m_buf[27:0], d};
    end
  endtask

  // Press for 40 cycles (enough to reach any column and debounce), then release.
  task automatic press_key(input logic [3:0] d, input string tag);
    logic [3:0] exp_col;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keymap[r][c] == d) begin
          press_r = 2'(r);
          press_c = 2'(c);
        end
    press_en = 1'b1;
    tick(40);
    exp_col = 4'b0001 << press_c;
    check({tag, "_colhold"}, {28'b0, col}, {28'b0, ~exp_col});
    press_en = 1'b0;
    tick(40);
    apply_digit(d);
    push_state(tag);
    drain(tag);
  endtask

  initial begin
    logic [3:0] ecol;
    rst     = 1'b0;
    keyCtrl = 1'b0;
    address = A_BUF;
    #12;
    check("rst_col", {28'b0, col}, 32'h0000_000E);
    check("rst_buf", keyData, 32'h0);
    check("rst_kv", {31'b0, keyValid}, 32'h0);
    rst = 1'b1;

    // Idle scan: after edge k the column index is (k/4)%4.
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      ecol = 4'b0001 << ((k / 4) % 4);
      check("idle_col", {28'b0, col}, {28'b0, ~ecol});
      check("idle_buf", keyData, 32'h0);
    end

    press_key(4'h6, "key6");
    tick(40);
    push_state("norepeat");
    drain("norepeat");
    press_key(4'hE, "star0");

    press_key(4'h1, "d1");
    press_key(4'h2, "d2");
    press_key(4'h3, "d3");
    press_key(4'hF, "hash");
    press_key(4'h5, "locked5");

    // Read-clear of the buffer while the entry is complete.
    address = A_BUF;
    keyCtrl = 1'b1;
    #1;
    check("rdclr_data", keyData, 32'h0000_0123);
    tick(1);
    keyCtrl = 1'b0;
    m_buf   = '0;
    m_valid = 1'b0;
    push_state("after_rdclr");
    drain("after_rdclr");

    // Read strobes without a completed entry, or of the flag address, change nothing.
    press_key(4'h7, "d7");
    address = A_BUF;
    keyCtrl = 1'b1;
    tick(1);
    push_state("rd_noval");
    drain("rd_noval");
    press_key(4'hF, "hash2");
    address = A_VLD;
    keyCtrl = 1'b1;
    tick(1);
    push_state("rd_vld");
    drain("rd_vld");
    press_key(4'hE, "star1");

    for (int i = 1; i <= 9; i++) press_key(4'(i), "nine");
    check("nine_model", m_buf, 32'h2345_6789);
    press_key(4'hE, "star2");

    // Single-sample glitch on row 0: exactly one sample point sees it.
    ovr_val = 4'b1110;
    ovr_en  = 1'b1;
    tick(SCAN_DIV);
    ovr_en  = 1'b0;
    tick(30);
    push_state("glitch");
    drain("glitch");

    ovr_val = 4'b1010;
    ovr_en  = 1'b1;
    tick(40);
    ovr_en  = 1'b0;
    tick(20);
    push_state("tworow");
    drain("tworow");

    // Reset while a key is held in HOLD, then re-registration after reset.
    press_r  = 2'd1;
    press_c  = 2'd1;
    press_en = 1'b1;
    tick(40);
    apply_digit(4'h5);
    push_state("hold5");
    drain("hold5");
    address = A_BUF;
    rst = 1'b0;
    #1;
    check("hrst_col", {28'b0, col}, 32'h0000_000E);
    check("hrst_buf", keyData, 32'h0);
    check("hrst_kv", {31'b0, keyValid}, 32'h0);
    m_buf   = '0;
    m_valid = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(40);
    apply_digit(4'h5);
    push_state("rereg5");
    drain("rereg5");
    press_en = 1'b0;
    tick(40);
    push_state("rereg_once");
    drain("rereg_once");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
